// File: rtl/mul_unit_pkg.sv
// Shared types and constants for the shift-add multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic       OP_MUL = 1'b0;
  localparam logic       OP_MLA = 1'b1;
  localparam logic [3:0] PC_IDX = 4'hF;

endpackage

// File: rtl/mul_unit_if.sv
// Request/write-back bundle between the execute stage and the multiplier.
interface mul_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [3:0]       rd_addr;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] src_acc;
  logic             busy;
  logic             done;
  logic             wb_we;
  logic [3:0]       wb_addr;
  logic [WIDTH-1:0] wb_data;
  logic             flag_n;
  logic             flag_z;
  logic             pc_dst_err;

  modport master (
    output start, op, rd_addr, src_a, src_b, src_acc,
    input  busy, done, wb_we, wb_addr, wb_data, flag_n, flag_z, pc_dst_err
  );

  modport slave (
    input  start, op, rd_addr, src_a, src_b, src_acc,
    output busy, done, wb_we, wb_addr, wb_data, flag_n, flag_z, pc_dst_err
  );
endinterface

// File: rtl/mul_unit_datapath.sv
// Shift-add datapath: multiplicand/multiplier shifters, product accumulator
// and step counter. The controlling FSM lives in mul_unit.
module mul_datapath
  import mul_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int EARLY_TERM = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [WIDTH-1:0] src_acc,
  output logic [WIDTH-1:0] prod,
  output logic             last
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] mplier_next;
  logic [CW-1:0]    cnt;

  // Flag the final iteration: counter exhausted, or no multiplier bits remain.
  always_comb begin
    mplier_next = mplier >> 1;
    last        = (cnt == CW'(WIDTH - 1)) ||
                  ((EARLY_TERM != 0) && (mplier_next == '0));
  end

  // Load operands on acceptance, then one add-and-shift per RUN cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
    end else if (load) begin
      mcand  <= src_a;
      mplier <= src_b;
      cnt    <= '0;
      prod   <= (op == OP_MLA) ? src_acc : '0;
    end else if (step) begin
      if (mplier[0]) begin
        prod <= prod + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier_next;
      cnt    <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mul_unit.sv
// Iterative MUL/MLA unit: IDLE -> RUN (shift-add) -> DONE, with a registered
// single-cycle register-file write-back request and sticky N/Z flags.
module mul_unit
  import mul_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int EARLY_TERM = 1
) (
  input  logic       clk,
  input  logic       rst,
  mul_unit_if.slave  bus
);

  state_t           state;
  state_t           next_state;
  logic             load;
  logic             step;
  logic             last;
  logic [3:0]       dst;
  logic [WIDTH-1:0] prod;

  mul_datapath #(
    .WIDTH      (WIDTH),
    .EARLY_TERM (EARLY_TERM)
  ) u_datapath (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .step    (step),
    .op      (bus.op),
    .src_a   (bus.src_a),
    .src_b   (bus.src_b),
    .src_acc (bus.src_acc),
    .prod    (prod),
    .last    (last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state logic; start is only honoured while IDLE.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Capture the destination register index at acceptance.
  always_ff @(posedge clk) begin
    if (!rst)      dst <= 4'h0;
    else if (load) dst <= bus.rd_addr;
  end

  // Registered write-back: pulses for one cycle after DONE, data/addr/flags hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.done       <= 1'b0;
      bus.wb_we      <= 1'b0;
      bus.pc_dst_err <= 1'b0;
      bus.wb_addr    <= 4'h0;
      bus.wb_data    <= '0;
      bus.flag_n     <= 1'b0;
      bus.flag_z     <= 1'b0;
    end else if (state == DONE) begin
      bus.done       <= 1'b1;
      bus.wb_we      <= (dst != PC_IDX);
      bus.pc_dst_err <= (dst == PC_IDX);
      bus.wb_addr    <= dst;
      bus.wb_data    <= prod;
      bus.flag_n     <= prod[WIDTH-1];
      bus.flag_z     <= (prod == '0);
    end else begin
      bus.done       <= 1'b0;
      bus.wb_we      <= 1'b0;
      bus.pc_dst_err <= 1'b0;
    end
  end

  assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed cases plus randomized operations
// compared against an arithmetic reference model.
module tb_mul_unit;
  import mul_pkg::*;

  localparam int WIDTH = 32;

  logic clk;
  logic rst;

  int tests;
  int failures;

  logic             oDone, oBusy, oWe, oN, oZ, oErr;
  logic [3:0]       oAddr;
  logic [WIDTH-1:0] oData;

  mul_unit_if #(.WIDTH(WIDTH)) bus0 ();
  mul_unit_if #(.WIDTH(WIDTH)) bus1 ();

  mul_unit #(.WIDTH(WIDTH), .EARLY_TERM(1)) dutEarly (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  mul_unit #(.WIDTH(WIDTH), .EARLY_TERM(0)) dutFull (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic grab(input bit full);
    if (full) begin
      oDone = bus1.done;  oBusy = bus1.busy;    oWe  = bus1.wb_we;
      oAddr = bus1.wb_addr; oData = bus1.wb_data;
      oN    = bus1.flag_n; oZ = bus1.flag_z;   oErr = bus1.pc_dst_err;
    end else begin
      oDone = bus0.done;  oBusy = bus0.busy;    oWe  = bus0.wb_we;
      oAddr = bus0.wb_addr; oData = bus0.wb_data;
      oN    = bus0.flag_n; oZ = bus0.flag_z;   oErr = bus0.pc_dst_err;
    end
  endtask

  // Drive one request and return #1 after the accepting edge with start low.
  task automatic applyStimulus(input bit full, input logic op, input logic [3:0] addr,
                               input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [WIDTH-1:0] acc);
    @(negedge clk);
    if (full) begin
      bus1.start = 1'b1; bus1.op = op; bus1.rd_addr = addr;
      bus1.src_a = a; bus1.src_b = b; bus1.src_acc = acc;
    end else begin
      bus0.start = 1'b1; bus0.op = op; bus0.rd_addr = addr;
      bus0.src_a = a; bus0.src_b = b; bus0.src_acc = acc;
    end
    @(posedge clk);
    #1;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
  endtask

  // Reference model: the architectural result and iteration count.
  function automatic logic [WIDTH-1:0] modelResult(input logic op, input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b,
                                                   input logic [WIDTH-1:0] acc);
    logic [63:0] full;
    full = {32'b0, a} * {32'b0, b} + ((op == OP_MLA) ? {32'b0, acc} : 64'd0);
    return full[WIDTH-1:0];
  endfunction

  function automatic int modelRuns(input bit full, input logic [WIDTH-1:0] b);
    int r;
    if (full) return WIDTH;
    r = $clog2({32'b0, b} + 64'd1);
    return (r < 1) ? 1 : r;
  endfunction

  // Called #1 after the accepting edge; follows the op to its write-back.
  task automatic checkOutput(input string tag, input bit full, input logic op,
                             input logic [3:0] addr, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] acc);
    logic [WIDTH-1:0] expData;
    int runs, latency, busyCycles, strayWe;
    expData    = modelResult(op, a, b, acc);
    runs       = modelRuns(full, b);
    grab(full);
    busyCycles = oBusy ? 1 : 0;
    strayWe    = 0;
    latency    = 201;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      grab(full);
      if (oDone) begin
        latency = n;
        break;
      end
      if (oBusy) busyCycles++;
      if (oWe) strayWe++;
    end
    checkValue({tag, ".latency"}, 64'(latency), 64'(runs + 1));
    checkValue({tag, ".busyCycles"}, 64'(busyCycles), 64'(runs + 1));
    checkValue({tag, ".strayWe"}, 64'(strayWe), 64'd0);
    checkValue({tag, ".busyAtDone"}, 64'(oBusy), 64'd0);
    checkValue({tag, ".wbData"}, 64'(oData), 64'(expData));
    checkValue({tag, ".wbAddr"}, 64'(oAddr), 64'(addr));
    checkValue({tag, ".wbWe"}, 64'(oWe), 64'(addr != PC_IDX));
    checkValue({tag, ".pcErr"}, 64'(oErr), 64'(addr == PC_IDX));
    checkValue({tag, ".flagN"}, 64'(oN), 64'(expData[WIDTH-1]));
    checkValue({tag, ".flagZ"}, 64'(oZ), 64'(expData == '0));
    @(posedge clk);
    #1;
    grab(full);
    checkValue({tag, ".doneAfter"}, 64'(oDone), 64'd0);
    checkValue({tag, ".weAfter"}, 64'(oWe), 64'd0);
    checkValue({tag, ".dataHeld"}, 64'(oData), 64'(expData));
    checkValue({tag, ".flagZHeld"}, 64'(oZ), 64'(expData == '0));
  endtask

  // Single linear sequence of directed and randomized steps.
  initial begin
    logic [WIDTH-1:0] ra, rb, racc, holdA, nextA;
    logic             rop;
    logic [3:0]       raddr;
    int               writes;

    tests = 0;
    failures = 0;
    bus0.start = 1'b0; bus0.op = 1'b0; bus0.rd_addr = 4'h0;
    bus0.src_a = '0; bus0.src_b = '0; bus0.src_acc = '0;
    bus1.start = 1'b0; bus1.op = 1'b0; bus1.rd_addr = 4'h0;
    bus1.src_a = '0; bus1.src_b = '0; bus1.src_acc = '0;

    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    grab(1'b0);
    checkValue("reset.busy", 64'(oBusy), 64'd0);
    checkValue("reset.done", 64'(oDone), 64'd0);
    checkValue("reset.wbWe", 64'(oWe), 64'd0);
    checkValue("reset.wbData", 64'(oData), 64'd0);
    checkValue("reset.flags", 64'({oN, oZ, oErr}), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    applyStimulus(1'b0, OP_MUL, 4'd2, 32'd3, 32'd5, 32'd0);
    checkOutput("mul3x5", 1'b0, OP_MUL, 4'd2, 32'd3, 32'd5, 32'd0);

    applyStimulus(1'b0, OP_MLA, 4'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
    checkOutput("mlaMax", 1'b0, OP_MLA, 4'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);

    applyStimulus(1'b0, OP_MLA, 4'd4, 32'd9, 32'd0, 32'd7);
    checkOutput("mlaB0", 1'b0, OP_MLA, 4'd4, 32'd9, 32'd0, 32'd7);

    applyStimulus(1'b0, OP_MUL, 4'd5, 32'd0, 32'd4, 32'd0);
    checkOutput("mulZero", 1'b0, OP_MUL, 4'd5, 32'd0, 32'd4, 32'd0);

    applyStimulus(1'b0, OP_MUL, 4'hF, 32'd2, 32'd3, 32'd0);
    checkOutput("mulPc", 1'b0, OP_MUL, 4'hF, 32'd2, 32'd3, 32'd0);

    // Hold start high while src_a churns during the 10*10 run.
    @(negedge clk);
    bus0.start = 1'b1; bus0.op = OP_MUL; bus0.rd_addr = 4'd3;
    bus0.src_a = 32'd10; bus0.src_b = 32'd10; bus0.src_acc = 32'd0;
    @(posedge clk);
    #1;
    writes = 0;
    holdA = 32'd10;
    oDone = 1'b0;
    for (int n = 0; n < 100 && !oDone; n++) begin
      @(negedge clk);
      holdA = $urandom;
      bus0.src_a = holdA;
      @(posedge clk);
      #1;
      grab(1'b0);
      if (oWe) writes++;
    end
    checkValue("hold.writes", 64'(writes), 64'd1);
    checkValue("hold.wbData", 64'(oData), 64'd100);
    checkValue("hold.busyAtDone", 64'(oBusy), 64'd0);
    @(negedge clk);
    nextA = $urandom_range(1, 1000);
    bus0.src_a = nextA;
    @(posedge clk);
    #1;
    bus0.start = 1'b0;
    checkOutput("holdSecond", 1'b0, OP_MUL, 4'd3, nextA, 32'd10, 32'd0);

    // Reset in the middle of a long run discards it.
    applyStimulus(1'b0, OP_MUL, 4'd6, 32'h0000_FFFF, 32'h0000_FFFF, 32'd0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    grab(1'b0);
    checkValue("midReset.busy", 64'(oBusy), 64'd0);
    checkValue("midReset.wbData", 64'(oData), 64'd0);
    checkValue("midReset.wbAddr", 64'(oAddr), 64'd0);
    checkValue("midReset.pulses", 64'({oDone, oWe, oErr, oN, oZ}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    writes = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      grab(1'b0);
      if (oWe || oDone) writes++;
    end
    checkValue("midReset.noWrite", 64'(writes), 64'd0);

    applyStimulus(1'b0, OP_MUL, 4'd1, 32'd6, 32'd7, 32'd0);
    checkOutput("mul6x7", 1'b0, OP_MUL, 4'd1, 32'd6, 32'd7, 32'd0);
    applyStimulus(1'b1, OP_MUL, 4'd1, 32'd6, 32'd7, 32'd0);
    checkOutput("mul6x7Full", 1'b1, OP_MUL, 4'd1, 32'd6, 32'd7, 32'd0);

    for (int i = 0; i < 8; i++) begin
      ra    = $urandom;
      rb    = $urandom >> $urandom_range(0, 31);
      racc  = $urandom;
      rop   = 1'($urandom_range(0, 1));
      raddr = 4'($urandom_range(0, 15));
      applyStimulus(i[0], rop, raddr, ra, rb, racc);
      checkOutput($sformatf("rand%0d", i), i[0], rop, raddr, ra, rb, racc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
